// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer for a valid/ready stream: in_ready is decoded from state only,
// so no combinational path runs from out_ready to in_ready. Also counts output transfers
// and latches upstream protocol violations.
module stream_skid_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             proto_err
);

  // State encodings equal the occupancy they represent.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   main_r;
  logic [WIDTH-1:0]   skid_r;
  logic               out_valid_r;
  logic [1:0]         occupancy_r;
  logic [CNT_W-1:0]   xfer_count_r;
  logic               proto_err_r;
  logic               stall_r;
  logic [WIDTH-1:0]   stall_data_r;
  logic               in_ready_s;
  logic               in_hs_s;
  logic               out_hs_s;
  logic               load_main_in_s;
  logic               load_main_skid_s;
  logic               load_skid_s;
  logic               proto_viol_s;

  assign in_hs_s  = in_valid && in_ready_s;
  assign out_hs_s = out_valid_r && out_ready;

  // State register with the registered status outputs that track it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      out_valid_r  <= 1'b0;
      occupancy_r  <= 2'd0;
      xfer_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occupancy_r <= state_nxt_s;
      if (out_hs_s) begin
        xfer_count_r <= xfer_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        xfer_count_r <= xfer_count_r;
      end
    end
  end

  // Next-state and register load-enable decode
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_hs_s) begin
          load_main_in_s = 1'b1;
          state_nxt_s    = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_hs_s && out_hs_s) begin
          load_main_in_s = 1'b1;
          state_nxt_s    = ST_ONE;
        end else if (in_hs_s) begin
          load_skid_s = 1'b1;
          state_nxt_s = ST_FULL;
        end else if (out_hs_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_hs_s) begin
          load_main_skid_s = 1'b1;
          state_nxt_s      = ST_ONE;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output decode: reset forces in_ready low so nothing is accepted in a reset cycle
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_FULL: in_ready_s = 1'b0;
        default: in_ready_s = 1'b1;
      endcase
    end
  end

  // Main and skid payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r <= {WIDTH{1'b0}};
      skid_r <= {WIDTH{1'b0}};
    end else begin
      if (load_main_in_s) begin
        main_r <= in_data;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  // A stalled word must be held stable with valid asserted until accepted.
  always_comb begin
    proto_viol_s = 1'b0;
    if (stall_r) begin
      proto_viol_s = !in_valid || (in_data != stall_data_r);
    end else begin
      proto_viol_s = 1'b0;
    end
  end

  // Stall history and sticky violation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r      <= 1'b0;
      stall_data_r <= {WIDTH{1'b0}};
      proto_err_r  <= 1'b0;
    end else begin
      stall_r      <= in_valid && !in_ready_s;
      stall_data_r <= in_data;
      proto_err_r  <= proto_err_r || proto_viol_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = main_r;
  assign occupancy  = occupancy_r;
  assign xfer_count = xfer_count_r;
  assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_stream_skid_buf.sv
// Directed bench for stream_skid_buf: vector table plus hand-written multi-cycle sequences,
// with an in-order scoreboard on the default-width instance.
module tb_stream_skid_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready,  in_ready4;
  logic        out_valid, out_valid4;
  logic [7:0]  out_data,  out_data4;
  logic [1:0]  occupancy, occupancy4;
  logic [15:0] xfer_count;
  logic [3:0]  xfer_count4;
  logic        proto_err, proto_err4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  stream_skid_buf #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .xfer_count(xfer_count), .proto_err(proto_err)
  );

  stream_skid_buf #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .xfer_count(xfer_count4), .proto_err(proto_err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
    logic       ir;
    logic [15:0] xc;
    logic       pe;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples handshakes mid-cycle, updates the scoreboard, then advances past the next edge.
  task automatic tick();
    logic       ih, oh;
    logic [7:0] od, exp_d;
    #1;
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    od = out_data;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (oh) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got word %0h expected none", od);
        end else begin
          exp_d = sb_q.pop_front();
          check("sb_order", {24'd0, od}, {24'd0, exp_d});
        end
      end
      if (ih) sb_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    //           rst   iv    d      ordy  ov    od     occ   ir    xc      pe
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 2'd1, 1'b1, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 2'd0, 1'b1, 16'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 16'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 16'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 2'd0, 1'b1, 16'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1, 16'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 2'd1, 1'b1, 16'd4, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 2'd1, 1'b1, 16'd4, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 2'd0, 1'b1, 16'd5, 1'b0};

    // Vector table: reset, single word, backpressure, simultaneous in/out in ONE.
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      tick();
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      check($sformatf("v%0d_out_data", i),  {24'd0, out_data},  {24'd0, vecs[i].od});
      check($sformatf("v%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].occ});
      check($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].ir});
      check($sformatf("v%0d_xfer_count", i), {16'd0, xfer_count}, {16'd0, vecs[i].xc});
      check($sformatf("v%0d_proto_err", i), {31'd0, proto_err}, {31'd0, vecs[i].pe});
    end

    // Streaming: 100 back-to-back words, one per cycle after one cycle of latency.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, i[7:0], 1'b1);
      tick();
      check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream%0d_data", i), {24'd0, out_data}, {24'd0, i[7:0]});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("stream_xfer_count", {16'd0, xfer_count}, 32'd100);
    check("stream_xfer_count4", {28'd0, xfer_count4}, 32'd4);
    check("stream_drained", {30'd0, occupancy}, 32'd0);

    // Violation: change data while stalled, flag sticks through traffic until reset.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h02, 1'b0);
    tick();
    check("viol_full_occ", {30'd0, occupancy}, 32'd2);
    check("viol_full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 1'b1, 8'h03, 1'b0);
    tick();
    check("viol_hold_ok", {31'd0, proto_err}, 32'd0);
    drive(1'b0, 1'b1, 8'h04, 1'b0);
    tick();
    check("viol_set", {31'd0, proto_err}, 32'd1);
    check("viol_data_kept", {24'd0, out_data}, 32'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("viol_drain_data", {24'd0, out_data}, 32'h02);
    tick();
    tick();
    check("viol_sticky", {31'd0, proto_err}, 32'd1);
    check("viol_empty", {30'd0, occupancy}, 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    check("viol_cleared", {31'd0, proto_err}, 32'd0);

    // Counter wrap on the 4-bit instance, then reset while full.
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 8'h80 + i[7:0], 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("wrap_xfer_count4", {28'd0, xfer_count4}, 32'd1);
    check("wrap_xfer_count", {16'd0, xfer_count}, 32'd17);
    drive(1'b0, 1'b1, 8'hA1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'hA2, 1'b0);
    tick();
    check("rstfull_occ_before", {30'd0, occupancy4}, 32'd2);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    check("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstfull_occ", {30'd0, occupancy}, 32'd0);
    check("rstfull_occ4", {30'd0, occupancy4}, 32'd0);
    check("rstfull_out_data", {24'd0, out_data}, 32'd0);
    check("rstfull_ready_in_rst", {31'd0, in_ready}, 32'd0);
    check("rstfull_xfer4", {28'd0, xfer_count4}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check("rstdrop_ready", {31'd0, in_ready}, 32'd1);
    check("rstdrop_ready4", {31'd0, in_ready4}, 32'd1);
    tick();
    check("rstdrop_empty", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_skid_buf.md
STREAM_SKID_BUF -- requirements
Module: stream_skid_buf

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter CNT_W, default 16: width of the transfer counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  downstream word present.
REQ-009 out_ready  input  1  downstream accepts the word this cycle.
REQ-010 out_data  output  WIDTH  downstream payload.
REQ-011 occupancy  output  2  number of words held, 0..2.
REQ-012 xfer_count  output  CNT_W  count of completed output handshakes.
REQ-013 proto_err  output  1  sticky upstream protocol-violation flag.

Function
REQ-014 An input handshake SHALL be in_valid && in_ready; an output handshake SHALL be out_valid && out_ready.
REQ-015 The block SHALL hold two registers, main and skid, and SHALL use three states: EMPTY (occupancy 0), ONE (main valid), and FULL (main and skid valid).
REQ-016 out_valid SHALL be 1 in ONE and FULL; out_data SHALL always be driven from main.
REQ-017 in_ready SHALL be 0 in FULL and 1 otherwise, decoded from state only, with no combinational path from out_ready.
REQ-018 EMPTY + input handshake: main <= in_data; next state ONE; the word appears on out_data one cycle after acceptance.
REQ-019 ONE + input handshake + output handshake: main <= in_data; state stays ONE.
REQ-020 ONE + input handshake + no output handshake: skid <= in_data; next state FULL.
REQ-021 ONE + output handshake + no input handshake: next state EMPTY.
REQ-022 FULL + output handshake: main <= skid; next state ONE.
REQ-023 FULL + no output handshake: state and data SHALL hold; in_valid is ignored.
REQ-024 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-025 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL, registered with the state.
REQ-026 xfer_count SHALL increment by 1 on each output handshake and wrap modulo 2^CNT_W (all-ones + 1 -> 0).
REQ-027 proto_err SHALL set when the previous cycle had in_valid=1 && in_ready=0 and the current cycle has in_valid=0 or a changed in_data.
REQ-028 proto_err SHALL remain set until reset; proto_err SHALL NOT alter data-path behaviour.
REQ-029 Main SHALL be loaded only from in_data or skid; skid SHALL be loaded only from in_data.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL enter EMPTY and drive out_valid=0, out_data=0, occupancy=0, xfer_count=0 and proto_err=0.
REQ-031 in_ready SHALL be 0 in any cycle where rst=1, and SHALL be 1 in the first cycle after rst falls.
REQ-032 Reset asserted mid-operation SHALL discard held words; no handshake SHALL occur in a reset cycle.

Verification
REQ-033 Single word: after reset, send 0x5A with out_ready=1 -> out_valid=1 and out_data=0x5A in the next cycle, then EMPTY; xfer_count=1.
REQ-034 Backpressure: out_ready=0, send 0x11 then 0x22 -> occupancy=2 and in_ready=0; raise out_ready -> 0x11 then 0x22 in consecutive cycles; occupancy returns to 0.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 100 cycles with an incrementing payload -> throughput of one word per cycle after one cycle of latency; output sequence matches input; xfer_count=100.
REQ-036 Violation: out_ready=0 with the block full, hold in_valid=1 and change in_data -> proto_err=1 next cycle; it stays 1 after traffic resumes until rst.
REQ-037 Wrap and reset: CNT_W=4, 17 transfers -> xfer_count=1; assert rst while FULL -> out_valid=0, occupancy=0, and in_ready=1 one cycle after rst drops.
